// File: rtl/hp_pkg.sv
// Shared types and constants for the human-presence frame scheduler.
// Used by every build; the HP_WATCHDOG_EN option changes nothing here.
package hp_pkg;

    localparam int unsigned Q_W   = 16;
    localparam int unsigned CNT_W = 9;

    localparam logic [Q_W-1:0] DEF_THRESHOLD = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_EVAL  = 2'd3
    } state_t;

endpackage

// File: rtl/hp_debounce.sv
// Hit/miss run-length debounce producing the presence flag; updates only on eval.
// Used by every build; the HP_WATCHDOG_EN option changes nothing here.
module hp_debounce #(
    parameter int unsigned DEB_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             eval,
    input  logic             hit,
    input  logic [DEB_W-1:0] on_cnt,
    input  logic [DEB_W-1:0] off_cnt,
    output logic             presence
);

    localparam int unsigned CW = DEB_W + 1;

    logic [DEB_W-1:0] hit_cnt;
    logic [DEB_W-1:0] hit_next;
    logic [DEB_W-1:0] miss_cnt;
    logic [DEB_W-1:0] miss_next;
    logic [DEB_W-1:0] on_eff;
    logic [DEB_W-1:0] off_eff;
    logic             presence_next;

    // A zero threshold behaves like one; the +1 compare is done one bit wider.
    always_comb begin
        on_eff        = (on_cnt == '0) ? DEB_W'(1) : on_cnt;
        off_eff       = (off_cnt == '0) ? DEB_W'(1) : off_cnt;
        hit_next      = hit_cnt;
        miss_next     = miss_cnt;
        presence_next = presence;
        if (eval) begin
            if (hit) begin
                miss_next = '0;
                if (hit_cnt != '1) begin
                    hit_next = hit_cnt + DEB_W'(1);
                end
                if (CW'(hit_cnt) + CW'(1) >= CW'(on_eff)) begin
                    presence_next = 1'b1;
                end
            end else begin
                hit_next = '0;
                if (miss_cnt != '1) begin
                    miss_next = miss_cnt + DEB_W'(1);
                end
                if (CW'(miss_cnt) + CW'(1) >= CW'(off_eff)) begin
                    presence_next = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            presence <= 1'b0;
        end else begin
            hit_cnt  <= hit_next;
            miss_cnt <= miss_next;
            presence <= presence_next;
        end
    end

endmodule

// File: rtl/hp_frame_scheduler.sv
// Per-frame inference scheduler: frame skipping, ML start, result latch, debounce, handshake.
// Define HP_WATCHDOG_EN to add a RUN-state watchdog and the o_timeout pulse.
module hp_frame_scheduler
    import hp_pkg::*;
#(
    parameter int unsigned NUM_LAYER = 4,
    parameter int unsigned SKIP_W    = 4,
    parameter int unsigned DEB_W     = 3,
    parameter int unsigned TO_W      = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_enable,
    input  logic              i_frame_start,
    input  logic [SKIP_W-1:0] i_skip,
    input  logic [Q_W-1:0]    i_threshold,
    input  logic [DEB_W-1:0]  i_on_cnt,
    input  logic [DEB_W-1:0]  i_off_cnt,
    output logic              o_ml_start,
    output logic              o_pp_init,
    input  logic              i_comp_done,
    input  logic [Q_W-1:0]    i_max_val,
    input  logic [CNT_W-1:0]  i_cnt_val,
    output logic              o_busy,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [Q_W-1:0]    o_res_max,
    output logic [CNT_W-1:0]  o_res_cnt,
    output logic              o_presence,
    output logic              o_err
`ifdef HP_WATCHDOG_EN
    ,
    output logic              o_timeout
`endif
);

    // Elaboration-time sanity check on the pass-through parameters.
    if (NUM_LAYER < 1 || TO_W < 2) begin : g_cfg_err
        $error("hp_frame_scheduler: NUM_LAYER must be >= 1 and TO_W >= 2");
    end

    state_t            state;
    state_t            state_next;
    logic [SKIP_W-1:0] skip_cnt;
    logic [SKIP_W-1:0] skip_next;
    logic              first_run;
    logic              overrun;
    logic              eval;
    logic              hit;
`ifdef HP_WATCHDOG_EN
    logic [TO_W-1:0]   wd_cnt;
    logic [TO_W-1:0]   wd_next;
    logic [TO_W-1:0]   wd_inc;
    logic              timeout_c;
`endif

    assign eval = (state == ST_EVAL);
    assign hit  = $signed(i_max_val) >= $signed(i_threshold);

    // Next-state logic; done is stale in the first RUN cycle so it is masked there.
    always_comb begin
        state_next = state;
        skip_next  = skip_cnt;
        overrun    = 1'b0;
`ifdef HP_WATCHDOG_EN
        wd_next    = '0;
        timeout_c  = 1'b0;
        wd_inc     = wd_cnt + TO_W'(1);
`endif
        case (state)
            ST_IDLE: begin
                if (i_frame_start && i_enable) begin
                    if (skip_cnt == '0) begin
                        state_next = ST_START;
                        skip_next  = i_skip;
                    end else begin
                        skip_next = skip_cnt - SKIP_W'(1);
                    end
                end
            end
            ST_START: state_next = ST_RUN;
            ST_RUN: begin
                if (!first_run && i_comp_done) begin
                    state_next = ST_EVAL;
                end
`ifdef HP_WATCHDOG_EN
                else if (wd_inc == '1) begin
                    state_next = ST_IDLE;
                    timeout_c  = 1'b1;
                end else begin
                    wd_next = wd_inc;
                end
`endif
            end
            ST_EVAL: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (state != ST_IDLE) begin
            overrun = i_frame_start && i_enable;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            skip_cnt    <= '0;
            first_run   <= 1'b0;
            o_ml_start  <= 1'b0;
            o_pp_init   <= 1'b0;
            o_busy      <= 1'b0;
            o_res_valid <= 1'b0;
            o_res_max   <= '0;
            o_res_cnt   <= '0;
            o_err       <= 1'b0;
`ifdef HP_WATCHDOG_EN
            wd_cnt      <= '0;
            o_timeout   <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            skip_cnt   <= skip_next;
            first_run  <= (state == ST_START);
            o_ml_start <= (state_next == ST_START);
            o_pp_init  <= (state_next == ST_START);
            o_busy     <= (state_next != ST_IDLE);
            // A fresh result always wins; an unconsumed older one is lost.
            if (eval) begin
                o_res_max   <= i_max_val;
                o_res_cnt   <= i_cnt_val;
                o_res_valid <= 1'b1;
            end else if (i_res_ready) begin
                o_res_valid <= 1'b0;
            end
            if (overrun || (eval && o_res_valid && !i_res_ready)) begin
                o_err <= 1'b1;
            end
`ifdef HP_WATCHDOG_EN
            wd_cnt    <= wd_next;
            o_timeout <= timeout_c;
            if (timeout_c) begin
                o_err <= 1'b1;
            end
`endif
        end
    end

    hp_debounce #(
        .DEB_W (DEB_W)
    ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .eval     (eval),
        .hit      (hit),
        .on_cnt   (i_on_cnt),
        .off_cnt  (i_off_cnt),
        .presence (o_presence)
    );

endmodule

// File: tb/tb_hp_frame_scheduler.sv
// Directed self-checking bench for hp_frame_scheduler.
// Define HP_WATCHDOG_EN to also exercise the watchdog (built with TO_W=4).
module tb_hp_frame_scheduler;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        frame_start;
    logic [3:0]  skip;
    logic [15:0] threshold;
    logic [2:0]  on_cnt;
    logic [2:0]  off_cnt;
    logic        ml_start;
    logic        pp_init;
    logic        comp_done;
    logic [15:0] max_val;
    logic [8:0]  cnt_val;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_max;
    logic [8:0]  res_cnt;
    logic        presence;
    logic        err;
`ifdef HP_WATCHDOG_EN
    logic        timeout;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    hp_frame_scheduler #(
        .NUM_LAYER (4),
        .SKIP_W    (4),
        .DEB_W     (3),
        .TO_W      (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_enable      (enable),
        .i_frame_start (frame_start),
        .i_skip        (skip),
        .i_threshold   (threshold),
        .i_on_cnt      (on_cnt),
        .i_off_cnt     (off_cnt),
        .o_ml_start    (ml_start),
        .o_pp_init     (pp_init),
        .i_comp_done   (comp_done),
        .i_max_val     (max_val),
        .i_cnt_val     (cnt_val),
        .o_busy        (busy),
        .o_res_valid   (res_valid),
        .i_res_ready   (res_ready),
        .o_res_max     (res_max),
        .o_res_cnt     (res_cnt),
        .o_presence    (presence),
        .o_err         (err)
`ifdef HP_WATCHDOG_EN
        ,
        .o_timeout     (timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        enable = 1'b1; frame_start = 1'b0; skip = 4'd0;
        threshold = 16'h0800; on_cnt = 3'd1; off_cnt = 3'd1;
        comp_done = 1'b0; max_val = 16'h0000; cnt_val = 9'd0; res_ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Full frame with done raised in the second RUN cycle; ends in IDLE with the result valid.
    task automatic do_frame(input logic [15:0] mv, input logic [8:0] cv);
        max_val = mv; cnt_val = cv;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        tick();
        tick();
        comp_done = 1'b1; tick(); comp_done = 1'b0;
        tick();
    endtask

    task automatic consume();
        res_ready = 1'b1; tick(); res_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] outs;
        apply_reset();
        outs = {ml_start, pp_init, busy, res_valid, presence, err, 4'b0};
        n_checks++;
        if (outs !== 10'b0 || res_max !== 16'h0 || res_cnt !== 9'h0)
            $display("FAIL reset_outputs got=%b max=%h cnt=%h want all zero", outs, res_max, res_cnt);
        else n_pass++;
    endtask

    task automatic test_basic();
        apply_reset();
        max_val = 16'h0900; cnt_val = 9'd37;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        n_checks++;
        if ({ml_start, pp_init, busy} !== 3'b111) $display("FAIL start_pulse got=%b want=111", {ml_start, pp_init, busy});
        else n_pass++;
        tick();
        n_checks++;
        if ({ml_start, pp_init} !== 2'b00) $display("FAIL start_one_cycle got=%b want=00", {ml_start, pp_init});
        else n_pass++;
        repeat (4) tick();
        comp_done = 1'b1; tick(); comp_done = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0) $display("FAIL valid_latency_early got=%b want=0", res_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (res_valid !== 1'b1 || res_max !== 16'h0900 || res_cnt !== 9'd37 || presence !== 1'b1)
            $display("FAIL basic_result valid=%b max=%h cnt=%0d pres=%b want 1/0900/37/1", res_valid, res_max, res_cnt, presence);
        else n_pass++;
        consume();
        n_checks++;
        if ({res_valid, err, busy} !== 3'b000) $display("FAIL basic_consume got=%b want=000", {res_valid, err, busy});
        else n_pass++;
    endtask

    task automatic test_skip();
        int         starts;
        logic [5:0] mask;
        apply_reset();
        skip = 4'd2; starts = 0; mask = '0;
        for (int i = 0; i < 6; i++) begin
            frame_start = 1'b1; tick(); frame_start = 1'b0;
            if (ml_start) begin
                starts++; mask[i] = 1'b1;
                tick(); tick();
                comp_done = 1'b1; tick(); comp_done = 1'b0;
                tick();
                consume();
            end else begin
                tick();
            end
        end
        n_checks++;
        if (starts != 2 || mask !== 6'b001001) $display("FAIL skip_pattern starts=%0d mask=%b want 2/001001", starts, mask);
        else n_pass++;
        // Frames while disabled must not advance the skip counter.
        apply_reset();
        skip = 4'd1;
        do_frame(16'h0100, 9'd1);
        consume();
        enable = 1'b0; frame_start = 1'b1; tick(); frame_start = 1'b0; enable = 1'b1;
        n_checks++;
        if (ml_start !== 1'b0) $display("FAIL disabled_frame got=%b want=0", ml_start);
        else n_pass++;
        tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        n_checks++;
        if (ml_start !== 1'b0) $display("FAIL skip_after_disabled got=%b want=0", ml_start);
        else n_pass++;
        tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        n_checks++;
        if (ml_start !== 1'b1) $display("FAIL start_after_skip got=%b want=1", ml_start);
        else n_pass++;
        tick(); tick();
        comp_done = 1'b1; tick(); comp_done = 1'b0;
        tick();
        consume();
    endtask

    task automatic test_debounce();
        logic [15:0] sc  [14] = '{16'h0900, 16'h0900, 16'h0900, 16'h0100, 16'h0100,
                                  16'h0900, 16'h0900, 16'h0900, 16'hF000, 16'hF000,
                                  16'h0800, 16'h07FF, 16'h0000, 16'h8000};
        logic [15:0] thr [14] = '{16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800,
                                  16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800,
                                  16'h0800, 16'h0800, 16'hFF00, 16'hFF00};
        logic [2:0]  onv [14] = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 0, 0, 0, 0};
        logic [2:0]  ofv [14] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 0, 0, 0, 0};
        logic        exp [14] = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0};
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            threshold = thr[i]; on_cnt = onv[i]; off_cnt = ofv[i];
            do_frame(sc[i], 9'(i));
            n_checks++;
            if (presence !== exp[i]) $display("FAIL debounce_%0d score=%h got=%b want=%b", i, sc[i], presence, exp[i]);
            else n_pass++;
            consume();
        end
        n_checks++;
        if (err !== 1'b0) $display("FAIL debounce_no_err got=%b want=0", err);
        else n_pass++;
    endtask

    task automatic test_stale_done();
        apply_reset();
        comp_done = 1'b1;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (res_valid !== 1'b0) $display("FAIL stale_done_masked got=%b want=0", res_valid);
        else n_pass++;
        tick();
        comp_done = 1'b0;
        n_checks++;
        if (res_valid !== 1'b1) $display("FAIL stale_done_result got=%b want=1", res_valid);
        else n_pass++;
        consume();
    endtask

    task automatic test_overrun();
        int extra;
        apply_reset();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        extra = 0;
        n_checks++;
        if (err !== 1'b1) $display("FAIL overrun_err got=%b want=1", err);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (ml_start) extra++;
            tick();
        end
        n_checks++;
        if (extra != 0 || busy !== 1'b1) $display("FAIL overrun_no_start extra=%0d busy=%b want 0/1", extra, busy);
        else n_pass++;
        comp_done = 1'b1; tick(); comp_done = 1'b0;
        tick();
        consume();
        n_checks++;
        if (err !== 1'b1) $display("FAIL err_sticky got=%b want=1", err);
        else n_pass++;
    endtask

    task automatic test_handshake();
        apply_reset();
        do_frame(16'h0900, 9'd1);
        do_frame(16'h0123, 9'd2);
        n_checks++;
        if (res_valid !== 1'b1 || res_max !== 16'h0123 || res_cnt !== 9'd2 || err !== 1'b1)
            $display("FAIL overwrite valid=%b max=%h cnt=%0d err=%b want 1/0123/2/1", res_valid, res_max, res_cnt, err);
        else n_pass++;
        apply_reset();
        do_frame(16'h0900, 9'd1);
        max_val = 16'h0456; cnt_val = 9'd3;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        tick(); tick();
        comp_done = 1'b1; tick(); comp_done = 1'b0;
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        n_checks++;
        if (res_valid !== 1'b1 || res_max !== 16'h0456 || res_cnt !== 9'd3 || err !== 1'b0)
            $display("FAIL ready_at_eval valid=%b max=%h cnt=%0d err=%b want 1/0456/3/0", res_valid, res_max, res_cnt, err);
        else n_pass++;
        consume();
        n_checks++;
        if (res_valid !== 1'b0) $display("FAIL ready_clears got=%b want=0", res_valid);
        else n_pass++;
    endtask

    task automatic test_mid_run();
        apply_reset();
        do_frame(16'h0900, 9'd5);
        consume();
        n_checks++;
        if (presence !== 1'b1) $display("FAIL pre_reset_presence got=%b want=1", presence);
        else n_pass++;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        n_checks++;
        if ({busy, presence, ml_start, res_valid, err} !== 5'b0)
            $display("FAIL mid_run_reset got=%b want=00000", {busy, presence, ml_start, res_valid, err});
        else n_pass++;
        tick(); tick();
        n_checks++;
        if ({busy, ml_start} !== 2'b00) $display("FAIL post_reset_idle got=%b want=00", {busy, ml_start});
        else n_pass++;
        // Dropping enable mid-frame must not abort it.
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        enable = 1'b0;
        tick(); tick();
        comp_done = 1'b1; tick(); comp_done = 1'b0;
        tick();
        enable = 1'b1;
        n_checks++;
        if (res_valid !== 1'b1) $display("FAIL enable_low_run got=%b want=1", res_valid);
        else n_pass++;
        consume();
    endtask

`ifdef HP_WATCHDOG_EN
    task automatic test_watchdog();
        int at;
        apply_reset();
        do_frame(16'h0900, 9'd1);
        consume();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        at = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (timeout) begin
                at = k;
                break;
            end
        end
        n_checks++;
        if (at != 16) $display("FAIL watchdog_time got=%0d want=16", at);
        else n_pass++;
        n_checks++;
        if ({busy, presence, err, res_valid} !== 4'b0110)
            $display("FAIL watchdog_state got=%b want=0110", {busy, presence, err, res_valid});
        else n_pass++;
        tick();
        n_checks++;
        if (timeout !== 1'b0) $display("FAIL watchdog_pulse got=%b want=0", timeout);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_skip();
        test_debounce();
        test_stale_done();
        test_overrun();
        test_handshake();
        test_mid_run();
`ifdef HP_WATCHDOG_EN
        test_watchdog();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
